pc_update_unit: RTL and testbench

//   Program-counter stage directly downstream of the PC-source mux in the multicycle CPU.
//   - Registers the mux output under unconditional (pc_write) or branch-qualified
//     (pc_write_cond) control.
//   - Captures EPC for the exception path.
//   - Optionally traps misaligned PC targets through a small request/acknowledge FSM
//     to the control unit.

---
 rtl/pc_update_unit.sv | 125 ++++++++++++
 tb/tb_pc_update_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_update_unit
// Description : Program-counter register stage fed by the PC-source mux.
//               Handles unconditional and branch-qualified PC writes, EPC
//               capture, and a write counter. Defining PC_ALIGN_CHECK_EN
//               builds the misaligned-target trap with its request/ack FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_update_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WIDTH-1:0] EPC_OFFSET = WIDTH'(4)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_pc_in,
    input  logic             i_pc_write,
    input  logic             i_pc_write_cond,
    input  logic [1:0]       i_branch_type,
    input  logic             i_alu_zero,
    input  logic             i_alu_gt,
    input  logic             i_epc_write,
    input  logic             i_exc_ack,
    output logic [WIDTH-1:0] o_pc_out,
    output logic [WIDTH-1:0] o_epc_out,
    output logic             o_pc_updated,
    output logic             o_misalign_exc,
    output logic [WIDTH-1:0] o_instr_count
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_cnt;
    logic             r_upd;

    logic w_cond;
    logic w_take;
    logic w_misalign;
    logic w_in_run;
    logic w_run_rules;
    logic w_load;
    logic w_trap;
    logic w_epc_cap;

    always_comb begin
        w_cond = 1'b0;
        case (i_branch_type)
            2'b00:   w_cond =  i_alu_zero;
            2'b01:   w_cond = ~i_alu_zero;
            2'b10:   w_cond =  i_alu_gt;
            default: w_cond = ~i_alu_gt;
        endcase
    end

    assign w_take = i_pc_write | (i_pc_write_cond & w_cond);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_EXC_PEND = 1'b1;

    logic [0:0] r_state;
    logic       r_exc;

    assign w_misalign  = (i_pc_in[1:0] != 2'b00);
    assign w_in_run    = (r_state == ST_RUN);
    // An ack leaves EXC_PEND in the same cycle, so a take alongside it runs normally
    assign w_run_rules = w_in_run | i_exc_ack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_exc   <= 1'b0;
        end else if (w_trap) begin
            r_state <= ST_EXC_PEND;
            r_exc   <= 1'b1;
        end else if (!w_in_run && i_exc_ack) begin
            r_state <= ST_RUN;
            r_exc   <= 1'b0;
        end
    end

    assign o_misalign_exc = r_exc;
`else
    logic w_unused_ack;

    assign w_unused_ack   = i_exc_ack;
    assign w_misalign     = 1'b0;
    assign w_in_run       = 1'b1;
    assign w_run_rules    = 1'b1;
    assign o_misalign_exc = 1'b0;
`endif

    assign w_load    = w_run_rules & w_take & ~w_misalign;
    assign w_trap    = w_run_rules & w_take &  w_misalign;
    // Explicit epc_write only counts in RUN; the first exception keeps its EPC
    assign w_epc_cap = (w_in_run & i_epc_write) | w_trap;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc  <= RESET_PC;
            r_epc <= '0;
            r_cnt <= '0;
            r_upd <= 1'b0;
        end else begin
            r_upd <= w_load;
            if (w_load) begin
                r_pc  <= i_pc_in;
                r_cnt <= r_cnt + c_one;
            end
            if (w_epc_cap) begin
                r_epc <= r_pc - EPC_OFFSET;
            end
        end
    end

    assign o_pc_out      = r_pc;
    assign o_epc_out     = r_epc;
    assign o_pc_updated  = r_upd;
    assign o_instr_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_update_unit
// Description : Self-checking bench for pc_update_unit (table vectors plus
//               hand sequences; covers PC_ALIGN_CHECK_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_update_unit;

    typedef struct packed {
        logic        pw;
        logic        pwc;
        logic [1:0]  bt;
        logic        z;
        logic        gt;
        logic        ew;
        logic        ack;
        logic [31:0] pc_in;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic        e_upd;
        logic        e_exc;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_write = 1'b0, pc_write_cond = 1'b0;
    logic [1:0]  branch_type = 2'b00;
    logic        alu_zero = 1'b0, alu_gt = 1'b0, epc_write = 1'b0, exc_ack = 1'b0;
    logic [31:0] pc_out, epc_out, instr_count;
    logic        pc_updated, misalign_exc;

    logic [7:0]  s_pc_in = '0;
    logic        s_pc_write = 1'b0;
    logic [7:0]  s_pc_out, s_epc_out, s_cnt;
    logic        s_upd, s_exc;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t sb[$];
    vec_t tbl[17];

    always #5 clk = ~clk;

    pc_update_unit #(.WIDTH(32), .RESET_PC(32'h0), .EPC_OFFSET(32'd4)) dut (
        .clk(clk), .reset(reset), .i_pc_in(pc_in), .i_pc_write(pc_write),
        .i_pc_write_cond(pc_write_cond), .i_branch_type(branch_type),
        .i_alu_zero(alu_zero), .i_alu_gt(alu_gt), .i_epc_write(epc_write),
        .i_exc_ack(exc_ack), .o_pc_out(pc_out), .o_epc_out(epc_out),
        .o_pc_updated(pc_updated), .o_misalign_exc(misalign_exc),
        .o_instr_count(instr_count)
    );

    // Narrow instance makes the counter wrap reachable and shows a non-zero RESET_PC
    pc_update_unit #(.WIDTH(8), .RESET_PC(8'h40), .EPC_OFFSET(8'd4)) dut_s (
        .clk(clk), .reset(reset), .i_pc_in(s_pc_in), .i_pc_write(s_pc_write),
        .i_pc_write_cond(1'b0), .i_branch_type(2'b00), .i_alu_zero(1'b0),
        .i_alu_gt(1'b0), .i_epc_write(1'b0), .i_exc_ack(1'b0),
        .o_pc_out(s_pc_out), .o_epc_out(s_epc_out), .o_pc_updated(s_upd),
        .o_misalign_exc(s_exc), .o_instr_count(s_cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pw, input logic pwc, input logic [1:0] bt,
                                input logic z, input logic gt, input logic ew,
                                input logic ack, input logic [31:0] pin,
                                input logic [31:0] e_pc, input logic [31:0] e_epc,
                                input logic e_upd, input logic e_exc,
                                input logic [31:0] e_cnt);
        vec_t v;
        v = '{pw, pwc, bt, z, gt, ew, ack, pin, e_pc, e_epc, e_upd, e_exc, e_cnt};
        return v;
    endfunction

    task automatic step(input vec_t v, input string nm);
        vec_t e;
        @(negedge clk);
        pc_write = v.pw;  pc_write_cond = v.pwc; branch_type = v.bt;
        alu_zero = v.z;   alu_gt = v.gt;         epc_write = v.ew;
        exc_ack  = v.ack; pc_in = v.pc_in;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({nm, ".pc"},  pc_out,                 e.e_pc);
        check({nm, ".epc"}, epc_out,                e.e_epc);
        check({nm, ".upd"}, {31'd0, pc_updated},    {31'd0, e.e_upd});
        check({nm, ".exc"}, {31'd0, misalign_exc},  {31'd0, e.e_exc});
        check({nm, ".cnt"}, instr_count,            e.e_cnt);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1'b0;
        pc_write = 1'b0; pc_write_cond = 1'b0; epc_write = 1'b0; exc_ack = 1'b0;
        s_pc_write = 1'b0;
        @(posedge clk);
        #1;
        check({nm, ".pc"},   pc_out,                0);
        check({nm, ".epc"},  epc_out,               0);
        check({nm, ".upd"},  {31'd0, pc_updated},   0);
        check({nm, ".exc"},  {31'd0, misalign_exc}, 0);
        check({nm, ".cnt"},  instr_count,           0);
        check({nm, ".spc"},  {24'd0, s_pc_out},     32'h40);
        check({nm, ".scnt"}, {24'd0, s_cnt},        0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        //             pw pwc bt    z  gt ew ack pc_in        pc           epc          upd exc cnt
        tbl[0]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0,        0, 0, 0);
        tbl[1]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h4,  32'h4,  32'h0,        1, 0, 1);
        tbl[2]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 32'h8,  32'h4,  32'h0,        0, 0, 1);
        tbl[3]  = mk(0, 1, 2'b01, 1, 0, 0, 0, 32'h40, 32'h4,  32'h0,        0, 0, 1);
        tbl[4]  = mk(0, 1, 2'b01, 0, 0, 0, 0, 32'h40, 32'h40, 32'h0,        1, 0, 2);
        tbl[5]  = mk(0, 1, 2'b00, 0, 1, 0, 0, 32'h80, 32'h40, 32'h0,        0, 0, 2);
        tbl[6]  = mk(0, 1, 2'b00, 1, 0, 0, 0, 32'h80, 32'h80, 32'h0,        1, 0, 3);
        tbl[7]  = mk(0, 1, 2'b10, 1, 0, 0, 0, 32'hC0, 32'h80, 32'h0,        0, 0, 3);
        tbl[8]  = mk(0, 1, 2'b10, 0, 1, 0, 0, 32'hC0, 32'hC0, 32'h0,        1, 0, 4);
        tbl[9]  = mk(0, 1, 2'b11, 0, 1, 0, 0, 32'h20, 32'hC0, 32'h0,        0, 0, 4);
        tbl[10] = mk(0, 1, 2'b11, 1, 0, 0, 0, 32'h20, 32'h20, 32'h0,        1, 0, 5);
        tbl[11] = mk(1, 0, 2'b00, 0, 0, 1, 0, 32'h24, 32'h24, 32'h1C,       1, 0, 6);
        tbl[12] = mk(0, 0, 2'b00, 0, 0, 1, 0, 32'h0,  32'h24, 32'h20,       0, 0, 6);
        tbl[13] = mk(1, 1, 2'b00, 0, 0, 0, 0, 32'h30, 32'h30, 32'h20,       1, 0, 7);
        tbl[14] = mk(0, 0, 2'b00, 0, 0, 0, 1, 32'h0,  32'h30, 32'h20,       0, 0, 7);
        tbl[15] = mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h0,  32'h0,  32'h20,       1, 0, 8);
        tbl[16] = mk(0, 0, 2'b00, 0, 0, 1, 0, 32'h0,  32'h0,  32'hFFFFFFFC, 0, 0, 8);

        repeat (2) @(posedge clk);
        do_reset("reset0");

        for (int i = 0; i < 17; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

`ifdef PC_ALIGN_CHECK_EN
        step(mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h8,   32'h8,  32'hFFFFFFFC, 1, 0, 9),  "al_set8");
        step(mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h12,  32'h8,  32'h4,        0, 1, 9),  "al_trap");
        step(mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h100, 32'h8,  32'h4,        0, 1, 9),  "al_ignw");
        step(mk(0, 0, 2'b00, 0, 0, 1, 0, 32'h0,   32'h8,  32'h4,        0, 1, 9),  "al_igne");
        step(mk(1, 0, 2'b00, 0, 0, 0, 1, 32'hFC,  32'hFC, 32'h4,        1, 0, 10), "al_ack");
        step(mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h13,  32'hFC, 32'hF8,       0, 1, 10), "al_trap2");
        step(mk(1, 0, 2'b00, 0, 0, 0, 1, 32'h21,  32'hFC, 32'hF8,       0, 1, 10), "al_retrap");
        do_reset("reset_pend");
        step(mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h10,  32'h10, 32'h0,        1, 0, 1),  "al_after");
`else
        step(mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h12,  32'h12, 32'hFFFFFFFC, 1, 0, 9),  "na_mis");
        step(mk(1, 0, 2'b00, 0, 0, 1, 1, 32'h13,  32'h13, 32'hE,        1, 0, 10), "na_mis2");
        do_reset("reset_mid");
        step(mk(0, 1, 2'b11, 0, 0, 0, 0, 32'h7,   32'h7,  32'h0,        1, 0, 1),  "na_after");
`endif

        // Counter wrap on the narrow instance: 255 writes to all-ones, one more to zero
        @(negedge clk);
        s_pc_write = 1'b1;
        s_pc_in    = 8'h04;
        repeat (255) @(posedge clk);
        #1;
        check("wrap.ff",  {24'd0, s_cnt},    32'hFF);
        check("wrap.pc",  {24'd0, s_pc_out}, 32'h04);
        @(posedge clk);
        #1;
        check("wrap.zero", {24'd0, s_cnt},   32'h0);
        check("wrap.upd",  {31'd0, s_upd},   32'h1);
        check("wrap.exc",  {31'd0, s_exc},   32'h0);
        check("wrap.epc",  {24'd0, s_epc_out}, 32'h0);
        @(negedge clk);
        s_pc_write = 1'b0;
        @(posedge clk);
        #1;
        check("wrap.upd0", {24'd0, s_cnt, 1'b0} >> 1, 32'h0);
        check("wrap.updlo", {31'd0, s_upd}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
